// File: rtl/nano_io_pkg.sv
// Shared definitions for the Nano MIPS output port display path:
// FSM state encoding, digit count and active-high 7-segment patterns
// (bit 0 = segment a ... bit 6 = segment g).
package nano_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BCD_W      = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction step for one BCD nibble.
  function automatic logic [NIBBLE_W-1:0] add3_ge5(input logic [NIBBLE_W-1:0] n);
    return (n >= 4'd5) ? NIBBLE_W'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/out_port_display_seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-high 7-segment pattern.
// Ports: nibble (4) digit value, blank (1) force all segments off,
//        seg_c (7) pattern, bit 0 = a ... bit 6 = g.
// Nibble values 10..15 decode to all segments off.
module seg7_decode
  import nano_io_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                blank,
  output logic [SEG_W-1:0]    seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/out_port_display.sv
// out_port_display: processor output port. Converts an 8-bit write to three
// decimal digits with a sequential double-dabble engine and scans them onto a
// common-segment 7-segment display.
// Ports: clk, rst_n (async active-low), wr_en/wr_data (write strobe + value),
//        busy (conversion running, writes dropped), seg[6:0] (a..g),
//        an[2:0] (active-low digit enables, 0=units 1=tens 2=hundreds).
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zeros.
module out_port_display
  import nano_io_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [SEG_W-1:0]  seg,
  output logic [2:0]        an
);

  localparam int unsigned        CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned        ITER_W    = 3;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [ITER_W-1:0]  ITER_LAST = ITER_W'(DATA_W - 1);
  localparam logic [SEG_W-1:0]   SEG_RST   = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [BCD_W-1:0]    digits_q, digits_d;   // {hundreds, tens, units}
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    refresh_q, refresh_d;
  logic [1:0]          idx_q, idx_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [2:0]          an_q, an_d;
  logic [NIBBLE_W-1:0] nibble_c;
  logic                blank_c;
  logic [SEG_W-1:0]    pattern_c;

  // Per-nibble add-3 correction ahead of the shift.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[i*NIBBLE_W +: NIBBLE_W] = add3_ge5(bcd_q[i*NIBBLE_W +: NIBBLE_W]);
    end
  end

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          bin_d   = wr_data;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        iter_d         = ITER_W'(iter_q + 1'b1);
        if (iter_q == ITER_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        digits_d = bcd_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Refresh counter and digit index; digit select uses next-cycle values so
  // an and seg update together with the index and with newly loaded digits.
  always_comb begin
    refresh_d = CNT_W'(refresh_q + 1'b1);
    idx_d     = idx_q;
    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      idx_d     = (idx_q == 2'd2) ? 2'd0 : 2'(idx_q + 2'd1);
    end
    an_d = ~(3'b001 << idx_d);
    case (idx_d)
      2'd1:    nibble_c = digits_d[4 +: NIBBLE_W];
      2'd2:    nibble_c = digits_d[8 +: NIBBLE_W];
      default: nibble_c = digits_d[0 +: NIBBLE_W];
    endcase
    blank_c = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_d == 2'd2 && digits_d[11:8] == 4'd0) blank_c = 1'b1;
    if (idx_d == 2'd1 && digits_d[11:4] == 8'd0) blank_c = 1'b1;
`endif
  end

  seg7_decode u_decode (
    .nibble (nibble_c),
    .blank  (blank_c),
    .seg_c  (pattern_c)
  );

  // Output polarity applied ahead of the segment register.
  always_comb begin
    seg_d = SEG_ACTIVE_LOW ? ~pattern_c : pattern_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
      refresh_q <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_RST;
      an_q      <= 3'b110;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_out_port_display.sv
// Self-checking bench for out_port_display (REFRESH_DIV=4, active-low).
// Reference model: decimal digits by divide/mod, scan position from the
// number of clock edges since reset release, fixed 9-cycle busy window.
module tb_out_port_display;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy;
  logic [6:0] seg;
  logic [2:0] an;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned shown      = 0;   // value the display should be showing
  int unsigned edges      = 0;   // clock edges since reset release

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  out_port_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .busy    (busy),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int unsigned val, input int unsigned pos);
    int unsigned d;
    bit blank;
    d = (pos == 0) ? val % 10 : (pos == 1) ? (val / 10) % 10 : val / 100;
    blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (pos == 2 && val < 100) blank = 1'b1;
    if (pos == 1 && val < 10)  blank = 1'b1;
`endif
    return blank ? 7'b1111111 : seg_tbl[d];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_display(input string tag);
    int unsigned pos;
    logic [2:0] an_exp;
    pos    = (edges / DIV) % 3;
    an_exp = ~(3'b001 << pos);
    chk({tag, "_an"}, 32'(an), 32'(an_exp));
    chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(shown, pos)));
  endtask

  // One write; optionally a second write mid-conversion which must be dropped.
  task automatic do_write(input int unsigned v, input bit inject);
    wr_en   = 1'b1;
    wr_data = 8'(v);
    step();                                   // edge k
    wr_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("busy_hi", 32'(busy), 32'd1);
      check_display("hold_old");
      if (inject && i == 2) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom_range(0, 255));
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
    shown = v;                                // edge k+9: new digits visible
    chk("busy_lo", 32'(busy), 32'd0);
    for (int i = 0; i < 3 * DIV; i++) begin
      check_display("scan");
      step();
    end
  endtask

  initial begin
    int unsigned v1, v2;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset held with clock running
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_an", 32'(an), 32'(3'b110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    rst_n = 1'b1;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      check_display("post_rst");
    end

    // Directed values including boundaries
    do_write(255, 1'b0);
    do_write(100, 1'b1);
    do_write(42, 1'b0);
    do_write(0, 1'b0);
    do_write(9, 1'b0);
    do_write(10, 1'b0);
    do_write(99, 1'b0);
    do_write(199, 1'b0);
    do_write(7, 1'b0);
    do_write(205, 1'b1);

    // Randomized writes with random gaps and dropped mid-conversion writes
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) begin
        check_display("gap");
        step();
      end
      do_write($urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end

    // wr_en held high: one conversion every 10 cycles
    v1 = $urandom_range(0, 255);
    v2 = $urandom_range(0, 255);
    wr_en   = 1'b1;
    wr_data = 8'(v1);
    step();                                   // edge k samples v1
    for (int i = 0; i < 9; i++) begin
      chk("cont_busy", 32'(busy), 32'd1);
      wr_data = (i == 8) ? 8'(v2) : 8'($urandom_range(0, 255));
      step();
    end
    shown = v1;
    chk("cont_idle", 32'(busy), 32'd0);
    check_display("cont_v1");
    step();                                   // edge k+10 samples v2
    wr_en = 1'b0;
    chk("cont_rearm", 32'(busy), 32'd1);
    repeat (9) step();
    shown = v2;
    chk("cont_done", 32'(busy), 32'd0);
    check_display("cont_v2");

    // Reset in the middle of converting 123
    wr_en   = 1'b1;
    wr_data = 8'd123;
    step();
    wr_en = 1'b0;
    repeat (4) step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    shown = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_an", 32'(an), 32'(3'b110));
    chk("mid_rst_seg", 32'(seg), 32'(7'b1000000));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4 * DIV; i++) begin
      step();
      chk("no_load_busy", 32'(busy), 32'd0);
      check_display("no_load");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
